// File: rtl/mac_tx_frame_arbiter.sv
// mac_tx_frame_arbiter: frame-level arbiter sharing the MAC TX path between CH_NUM sources
// Ports: logic_clk / logic_rst (synchronous, active-high);
//   arb_req_data_in/valid_in/last_in, arb_req_ready_out : per-channel byte streams;
//   mac_rnet_data/valid/last_out, mac_rnet_ready_in      : forwarded stream to the CRC stage;
//   arb_grant_out : one-hot grant; arb_busy_out : high in XFER or GAP.
// Build option MAC_TX_ARB_FIXED_PRIO_EN: lowest-index requester wins instead of round robin.
module mac_tx_frame_arbiter #(
  parameter int CH_NUM     = 2,
  parameter int IFG_CYCLES = 12
) (
  input  logic                  logic_clk,
  input  logic                  logic_rst,
  input  logic [8*CH_NUM-1:0]   arb_req_data_in,
  input  logic [CH_NUM-1:0]     arb_req_valid_in,
  input  logic [CH_NUM-1:0]     arb_req_last_in,
  output logic [CH_NUM-1:0]     arb_req_ready_out,
  output logic [7:0]            mac_rnet_data_out,
  output logic                  mac_rnet_valid_out,
  output logic                  mac_rnet_last_out,
  input  logic                  mac_rnet_ready_in,
  output logic [CH_NUM-1:0]     arb_grant_out,
  output logic                  arb_busy_out
);
  localparam int CW = CH_NUM > 1 ? $clog2(CH_NUM) : 1;
  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;
  state_t state_q, state_d;
  logic [CH_NUM-1:0] grant_q, grant_d;
  logic [7:0] cnt_q, cnt_d;
  logic [CW-1:0] win;
  logic beat_last;
`ifndef MAC_TX_ARB_FIXED_PRIO_EN
  logic [CW-1:0] last_ch_q, last_ch_d;
`endif
  // Descending search so the last hit is the highest-priority candidate.
  always_comb begin
    logic [CW-1:0] idx;
    idx = '0;
    win = '0;
`ifdef MAC_TX_ARB_FIXED_PRIO_EN
    for (int k = CH_NUM - 1; k >= 0; k--) begin
      idx = CW'(k);
      if (arb_req_valid_in[idx]) win = idx;
    end
`else
    for (int k = CH_NUM; k >= 1; k--) begin
      idx = CW'((int'(last_ch_q) + k) % CH_NUM);
      if (arb_req_valid_in[idx]) win = idx;
    end
`endif
  end
  // Grant is only nonzero in XFER, so IDLE and GAP drive all zeros here.
  always_comb begin
    mac_rnet_data_out = '0;
    mac_rnet_valid_out = 1'b0;
    mac_rnet_last_out = 1'b0;
    arb_req_ready_out = '0;
    for (int i = 0; i < CH_NUM; i++)
      if (grant_q[i]) begin
        mac_rnet_data_out = arb_req_data_in[8*i +: 8];
        mac_rnet_valid_out = arb_req_valid_in[i];
        mac_rnet_last_out = arb_req_last_in[i];
        arb_req_ready_out[i] = mac_rnet_ready_in;
      end
  end
  assign beat_last = mac_rnet_valid_out & mac_rnet_ready_in & mac_rnet_last_out;
  assign arb_grant_out = grant_q;
  assign arb_busy_out = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d = cnt_q;
`ifndef MAC_TX_ARB_FIXED_PRIO_EN
    last_ch_d = last_ch_q;
`endif
    case (state_q)
      IDLE:
        if (|arb_req_valid_in) begin
          state_d = XFER;
          grant_d = {{(CH_NUM-1){1'b0}}, 1'b1} << win;
`ifndef MAC_TX_ARB_FIXED_PRIO_EN
          last_ch_d = win;
`endif
        end
      XFER:
        if (beat_last) begin
          state_d = GAP;
          grant_d = '0;
          cnt_d = 8'(IFG_CYCLES - 1);
        end
      GAP: begin
        state_d = cnt_q == 8'd0 ? IDLE : GAP;
        cnt_d = cnt_q == 8'd0 ? cnt_q : cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge logic_clk) begin
    if (logic_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      cnt_q <= '0;
`ifndef MAC_TX_ARB_FIXED_PRIO_EN
      last_ch_q <= CW'(CH_NUM - 1);
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q <= cnt_d;
`ifndef MAC_TX_ARB_FIXED_PRIO_EN
      last_ch_q <= last_ch_d;
`endif
    end
  end
endmodule
